// File: rtl/mem_unit_pkg.sv
// Shared types and helpers for the memory interface unit.
package mem_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } mem_state_t;

  // Wide enough to hold the value TIMEOUT itself.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_unit_if.sv
// Memory-side request/response bus: the unit is master, the memory is slave.
interface mem_unit_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic [WIDTH-1:0]      mem_rdata;
  logic                  mem_rd;
  logic                  mem_wr;
  logic                  mem_ready;

  modport master (
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/mem_unit_timeout_counter.sv
// Wait-cycle counter; expire_o flags the enabled edge on which the count would reach TIMEOUT.
module timeout_counter
  import mem_unit_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int               CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_unit.sv
// MAR/MDR holder with tri-state bus drivers and a read/write FSM against a
// ready-handshaked memory, aborting with a sticky error after TIMEOUT waits.
module mem_unit
  import mem_unit_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             ld_mar,
  input  logic             ld_mdr,
  input  logic             oe_mar,
  input  logic             oe_mdr,
  input  logic             start_rd,
  input  logic             start_wr,
  output tri   [WIDTH-1:0] a,
  output tri   [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             err,
  mem_unit_if.master       mem
);

  mem_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] mar_q, mar_d;
  logic [WIDTH-1:0]      mdr_q, mdr_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic                  busy_q, rd_q, wr_q;
  logic                  cnt_clr, cnt_en, expire;

  timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .expire_o (expire)
  );

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    err_d   = err_q;
    done_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_mar) mar_d = in[ADDR_WIDTH-1:0];
        if (ld_mdr) mdr_d = in;
        if (start_rd || start_wr) begin
          cnt_clr = 1'b1;
          err_d   = 1'b0;
          if (start_rd && start_wr) err_d   = 1'b1;
          else if (start_rd)        state_d = READ;
          else                      state_d = WRITE;
        end
      end
      READ, WRITE: begin
        // A ready on the expiring edge still counts as a normal completion.
        cnt_en = !mem.mem_ready;
        if (mem.mem_ready) begin
          if (state_q == READ) mdr_d = mem.mem_rdata;
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (expire) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= (state_d != IDLE);
      rd_q    <= (state_d == READ);
      wr_q    <= (state_d == WRITE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

  assign mem.mem_addr  = mar_q;
  assign mem.mem_wdata = mdr_q;
  assign mem.mem_rd    = rd_q;
  assign mem.mem_wr    = wr_q;

  assign a = oe_mdr ? mdr_q : 'z;
  assign b = oe_mar ? WIDTH'(mar_q) : 'z;

endmodule

// File: tb/tb_mem_unit.sv
// Directed bench for mem_unit: stimulus queues expected completions, a monitor checks them on done.
module tb_mem_unit;

  localparam int W  = 32;
  localparam int AW = 16;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  in;
  logic          ld_mar, ld_mdr, oe_mar, oe_mdr, start_rd, start_wr;
  wire  [W-1:0]  a, b;
  logic          busy, done, err;

  mem_unit_if #(.WIDTH(W), .ADDR_WIDTH(AW)) mif ();

  mem_unit #(.WIDTH(W), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .ld_mar   (ld_mar),
    .ld_mdr   (ld_mdr),
    .oe_mar   (oe_mar),
    .oe_mdr   (oe_mdr),
    .start_rd (start_rd),
    .start_wr (start_wr),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem      (mif.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Completion monitor: every done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mif.mem_rd || mif.mem_wr)
      chk("req_exclusive", 64'(mif.mem_rd & mif.mem_wr), 64'd0);
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done required=no_done at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("done_addr", 64'(mif.mem_addr), 64'(mon_e.addr));
        chk("done_data", 64'(mif.mem_wdata), 64'(mon_e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int rd_cycles;
    rst_n = 1'b0; in = '0;
    ld_mar = 0; ld_mdr = 0; oe_mar = 0; oe_mdr = 0; start_rd = 0; start_wr = 0;
    mif.mem_rdata = '0; mif.mem_ready = 1'b0;

    // Reset state
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rd", 64'(mif.mem_rd), 64'd0);
    chk("rst_wr", 64'(mif.mem_wr), 64'd0);
    chk("rst_addr", 64'(mif.mem_addr), 64'd0);
    chk("rst_wdata", 64'(mif.mem_wdata), 64'd0);
    rst_n = 1'b1;
    tick();

    // Read with 3 wait cycles; ready lands on the timeout edge and still completes
    in = 32'hABCD_0100; ld_mar = 1;
    tick();
    ld_mar = 0;
    chk("mar_load", 64'(mif.mem_addr), 64'h0100);
    oe_mar = 1; #1;
    chk("b_zext", 64'(b), 64'h0000_0100);
    oe_mar = 0;
    sb.push_back('{addr: 16'h0100, data: 32'hDEAD_BEEF});
    mif.mem_rdata = 32'hDEAD_BEEF; start_rd = 1;
    tick();
    start_rd = 0;
    chk("rd_busy", 64'(busy), 64'd1);
    rd_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (mif.mem_rd) rd_cycles++;
      if (i == 3) mif.mem_ready = 1'b1;
      tick();
    end
    mif.mem_ready = 1'b0;
    chk("rd_hold_cycles", 64'(rd_cycles), 64'd4);
    chk("rd_done", 64'(done), 64'd1);
    chk("rd_err", 64'(err), 64'd0);
    chk("rd_req_low", 64'(mif.mem_rd), 64'd0);
    chk("rd_busy_low", 64'(busy), 64'd0);
    oe_mdr = 1; #1;
    chk("a_mdr", 64'(a), 64'hDEAD_BEEF);
    oe_mdr = 0;
    tick();
    chk("done_pulse", 64'(done), 64'd0);

    // Write with immediate ready; ready in IDLE must be ignored
    in = 32'h20; ld_mar = 1;
    tick();
    in = 32'h1234_5678; ld_mar = 0; ld_mdr = 1;
    tick();
    ld_mdr = 0; mif.mem_ready = 1'b1;
    tick();
    chk("idle_ready_busy", 64'(busy), 64'd0);
    chk("idle_ready_done", 64'(done), 64'd0);
    sb.push_back('{addr: 16'h0020, data: 32'h1234_5678});
    start_wr = 1;
    tick();
    start_wr = 0;
    chk("wr_req", 64'(mif.mem_wr), 64'd1);
    chk("wr_addr", 64'(mif.mem_addr), 64'h20);
    chk("wr_wdata", 64'(mif.mem_wdata), 64'h1234_5678);
    tick();
    mif.mem_ready = 1'b0;
    chk("wr_req_low", 64'(mif.mem_wr), 64'd0);
    chk("wr_done", 64'(done), 64'd1);

    // Timeout: abort on the 4th edge after start, MDR untouched
    mif.mem_rdata = 32'h5555_5555; start_rd = 1;
    tick();
    start_rd = 0;
    tick(); tick(); tick();
    chk("tmo_still_busy", 64'(busy), 64'd1);
    chk("tmo_err_early", 64'(err), 64'd0);
    tick();
    chk("tmo_busy", 64'(busy), 64'd0);
    chk("tmo_err", 64'(err), 64'd1);
    chk("tmo_done", 64'(done), 64'd0);
    chk("tmo_req", 64'(mif.mem_rd), 64'd0);
    oe_mdr = 1; #1;
    chk("tmo_mdr_kept", 64'(a), 64'h1234_5678);
    oe_mdr = 0;
    tick();
    chk("err_sticky", 64'(err), 64'd1);
    sb.push_back('{addr: 16'h0020, data: 32'h1234_5678});
    mif.mem_ready = 1'b1; start_wr = 1;
    tick();
    start_wr = 0;
    chk("start_clears_err", 64'(err), 64'd0);
    tick();
    mif.mem_ready = 1'b0;
    chk("post_tmo_done", 64'(done), 64'd1);

    // Simultaneous starts: no request, error flagged
    start_rd = 1; start_wr = 1;
    tick();
    start_rd = 0; start_wr = 0;
    chk("both_err", 64'(err), 64'd1);
    chk("both_busy", 64'(busy), 64'd0);
    chk("both_rd", 64'(mif.mem_rd), 64'd0);
    chk("both_wr", 64'(mif.mem_wr), 64'd0);

    // Loads and starts while busy are dropped
    sb.push_back('{addr: 16'h0020, data: 32'hCAFE_F00D});
    mif.mem_rdata = 32'hCAFE_F00D; start_rd = 1;
    tick();
    in = 32'h0000_0777; ld_mar = 1; ld_mdr = 1;
    tick();
    start_rd = 0; ld_mar = 0; ld_mdr = 0;
    chk("busy_mar_kept", 64'(mif.mem_addr), 64'h20);
    chk("busy_err_cleared", 64'(err), 64'd0);
    mif.mem_ready = 1'b1;
    tick();
    mif.mem_ready = 1'b0;
    chk("busy_rd_done", 64'(done), 64'd1);
    tick();
    chk("no_second_txn", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a read
    start_rd = 1;
    tick();
    start_rd = 0;
    chk("pre_rst_rd", 64'(mif.mem_rd), 64'd1);
    rst_n = 1'b0; #1;
    chk("arst_rd", 64'(mif.mem_rd), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_mar", 64'(mif.mem_addr), 64'd0);
    chk("arst_mdr", 64'(mif.mem_wdata), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 64'(busy), 64'd0);
    chk("post_rst_rd", 64'(mif.mem_rd), 64'd0);

    tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
